// File: rtl/ray_frame_scheduler_pkg.sv
// Shared types and defaults for the ray-casting frame pipeline: FSM states,
// camera word type and column-index sizing helper.
package ray_frame_scheduler_pkg;

    localparam int SCREEN_WIDTH_DEF = 320;
    localparam int N_DEF            = 24;

    // Camera snapshot word slots, in port order.
    localparam int CAM_WORDS   = 6;
    localparam int CAM_POS_X   = 0;
    localparam int CAM_POS_Y   = 1;
    localparam int CAM_DIR_X   = 2;
    localparam int CAM_DIR_Y   = 3;
    localparam int CAM_PLANE_X = 4;
    localparam int CAM_PLANE_Y = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    typedef logic signed [N_DEF-1:0] cam_word_t;

    function automatic int col_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ray_frame_scheduler_if.sv
// Column-request handshake plus the frame-latched camera snapshot that
// travels with every request to the ray-calculation stage.
interface ray_frame_scheduler_if
    import ray_frame_scheduler_pkg::*;
#(
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
    parameter int N            = N_DEF
);
    localparam int COL_W = col_width(SCREEN_WIDTH);

    logic             col_valid_out;
    logic             col_ready_in;
    logic [COL_W-1:0] col_out;
    logic             col_last_out;
    logic [N-1:0]     pos_x_out;
    logic [N-1:0]     pos_y_out;
    logic [N-1:0]     dir_x_out;
    logic [N-1:0]     dir_y_out;
    logic [N-1:0]     plane_x_out;
    logic [N-1:0]     plane_y_out;

    modport master (
        output col_valid_out, col_out, col_last_out,
        output pos_x_out, pos_y_out, dir_x_out, dir_y_out, plane_x_out, plane_y_out,
        input  col_ready_in
    );

    modport slave (
        input  col_valid_out, col_out, col_last_out,
        input  pos_x_out, pos_y_out, dir_x_out, dir_y_out, plane_x_out, plane_y_out,
        output col_ready_in
    );

endinterface

// File: rtl/ray_frame_scheduler_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear has priority
// over increment.
module ray_frame_scheduler_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ray_frame_scheduler.sv
// Per-frame column issuer: latches the camera on frame_go, streams column
// requests 0..SCREEN_WIDTH-1, then waits for render_done or a drain timeout.
module ray_frame_scheduler
    import ray_frame_scheduler_pkg::*;
#(
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int N             = N_DEF,
    parameter int DRAIN_TIMEOUT = 1 << 20
) (
    input  logic         pixel_clk_in,
    input  logic         rst_in,
    input  logic         enable_in,
    input  logic         frame_go_in,
    input  logic [N-1:0] pos_x_in,
    input  logic [N-1:0] pos_y_in,
    input  logic [N-1:0] dir_x_in,
    input  logic [N-1:0] dir_y_in,
    input  logic [N-1:0] plane_x_in,
    input  logic [N-1:0] plane_y_in,
    input  logic         render_done_in,
    ray_frame_scheduler_if.master col_if,
    output logic         busy_out,
    output logic [7:0]   skipped_out,
    output logic         timeout_err_out,
    output logic         stray_done_err_out
);

    localparam int               COL_W    = col_width(SCREEN_WIDTH);
    localparam int               DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_WIDTH - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_next;
    logic             r_valid;
    logic             r_last;
    logic             r_busy;
    logic             r_timeout_err;
    logic             r_stray_err;
    logic             w_latch;
    logic             w_timeout;
    logic [DRAIN_W-1:0] w_drain_cnt;

    logic [CAM_WORDS-1:0][N-1:0] w_cam_in;
    logic [CAM_WORDS-1:0][N-1:0] w_cam_q;

    assign w_cam_in[CAM_POS_X]   = pos_x_in;
    assign w_cam_in[CAM_POS_Y]   = pos_y_in;
    assign w_cam_in[CAM_DIR_X]   = dir_x_in;
    assign w_cam_in[CAM_DIR_Y]   = dir_y_in;
    assign w_cam_in[CAM_PLANE_X] = plane_x_in;
    assign w_cam_in[CAM_PLANE_Y] = plane_y_in;

    // The snapshot only moves in LATCH, so ray stages see one coherent camera per frame.
    genvar gi;
    generate
        for (gi = 0; gi < CAM_WORDS; gi++) begin : g_cam
            logic [N-1:0] r_word;
            always_ff @(posedge pixel_clk_in) begin
                if (rst_in) begin
                    r_word <= '0;
                end else if (w_latch) begin
                    r_word <= w_cam_in[gi];
                end
            end
            assign w_cam_q[gi] = r_word;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_latch      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_go_in && enable_in) begin
                    w_state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_latch      = 1'b1;
                w_col_next   = '0;
                w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (col_if.col_ready_in) begin
                    if (r_col == LAST_COL) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_col_next = r_col + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // A done pulse wins over a timeout landing on the same cycle.
                if (render_done_in) begin
                    w_state_next = ST_IDLE;
                end else if (w_drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
                    w_state_next = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_state       <= ST_IDLE;
            r_col         <= '0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stray_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
            r_valid <= (w_state_next == ST_ISSUE);
            r_last  <= (w_state_next == ST_ISSUE) && (w_col_next == LAST_COL);
            r_busy  <= (w_state_next != ST_IDLE);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (render_done_in && (r_state != ST_DRAIN)) begin
                r_stray_err <= 1'b1;
            end
        end
    end

    ray_frame_scheduler_sat_counter #(
        .WIDTH (8)
    ) u_skip_cnt (
        .clk     (pixel_clk_in),
        .srst    (rst_in),
        .i_clr   (1'b0),
        .i_inc   (frame_go_in && (r_state != ST_IDLE)),
        .o_count (skipped_out)
    );

    // Held at zero outside DRAIN so each drain window starts counting from zero.
    ray_frame_scheduler_sat_counter #(
        .WIDTH (DRAIN_W)
    ) u_drain_cnt (
        .clk     (pixel_clk_in),
        .srst    (rst_in),
        .i_clr   (r_state != ST_DRAIN),
        .i_inc   (r_state == ST_DRAIN),
        .o_count (w_drain_cnt)
    );

    assign col_if.col_valid_out = r_valid;
    assign col_if.col_out       = r_col;
    assign col_if.col_last_out  = r_last;
    assign col_if.pos_x_out     = w_cam_q[CAM_POS_X];
    assign col_if.pos_y_out     = w_cam_q[CAM_POS_Y];
    assign col_if.dir_x_out     = w_cam_q[CAM_DIR_X];
    assign col_if.dir_y_out     = w_cam_q[CAM_DIR_Y];
    assign col_if.plane_x_out   = w_cam_q[CAM_PLANE_X];
    assign col_if.plane_y_out   = w_cam_q[CAM_PLANE_Y];

    assign busy_out           = r_busy;
    assign timeout_err_out    = r_timeout_err;
    assign stray_done_err_out = r_stray_err;

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Directed frame scenarios followed by a randomized soak, every cycle compared
// against a frame-level model of the scheduler.
module tb_ray_frame_scheduler;
    import ray_frame_scheduler_pkg::*;

    localparam int W  = 320;
    localparam int NW = 24;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, go, done;
    logic [NW-1:0] cam_in [CAM_WORDS];
    logic          busy, tout, stray;
    logic [7:0]    skipped;

    ray_frame_scheduler_if #(.SCREEN_WIDTH(W), .N(NW)) col_if ();

    ray_frame_scheduler #(
        .SCREEN_WIDTH  (W),
        .N             (NW),
        .DRAIN_TIMEOUT (TO)
    ) dut (
        .pixel_clk_in       (clk),
        .rst_in             (rst),
        .enable_in          (en),
        .frame_go_in        (go),
        .pos_x_in           (cam_in[CAM_POS_X]),
        .pos_y_in           (cam_in[CAM_POS_Y]),
        .dir_x_in           (cam_in[CAM_DIR_X]),
        .dir_y_in           (cam_in[CAM_DIR_Y]),
        .plane_x_in         (cam_in[CAM_PLANE_X]),
        .plane_y_in         (cam_in[CAM_PLANE_Y]),
        .render_done_in     (done),
        .col_if             (col_if),
        .busy_out           (busy),
        .skipped_out        (skipped),
        .timeout_err_out    (tout),
        .stray_done_err_out (stray)
    );

    logic [NW-1:0] cam_out [CAM_WORDS];
    assign cam_out[CAM_POS_X]   = col_if.pos_x_out;
    assign cam_out[CAM_POS_Y]   = col_if.pos_y_out;
    assign cam_out[CAM_DIR_X]   = col_if.dir_x_out;
    assign cam_out[CAM_DIR_Y]   = col_if.dir_y_out;
    assign cam_out[CAM_PLANE_X] = col_if.plane_x_out;
    assign cam_out[CAM_PLANE_Y] = col_if.plane_y_out;

    int n_tests, n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: a frame is "started", "latched", has sent some
    // columns and has spent some cycles waiting for render_done.
    bit            m_in_frame, m_latched, m_tout, m_stray, m_frame_done;
    int            m_sent, m_drain, m_skips, m_issue_cycles, m_frames;
    logic [NW-1:0] m_snap [CAM_WORDS];
    int            seen [W];

    function automatic bit exp_valid();
        return m_in_frame && m_latched && (m_sent < W);
    endfunction

    function automatic bit exp_drain();
        return m_in_frame && m_latched && (m_sent == W);
    endfunction

    function automatic int exp_col();
        return (m_sent >= W) ? W - 1 : m_sent;
    endfunction

    task automatic model_clock();
        bit idle;
        bit draining;
        if (rst) begin
            m_in_frame = 0; m_latched = 0; m_tout = 0; m_stray = 0;
            m_sent = 0; m_drain = 0; m_skips = 0; m_issue_cycles = 0;
            foreach (m_snap[i]) m_snap[i] = '0;
            foreach (seen[i]) seen[i] = 0;
            return;
        end
        idle     = !m_in_frame;
        draining = exp_drain();
        if (exp_valid()) m_issue_cycles++;
        if (go && !idle && m_skips < 255) m_skips++;
        if (done && !draining) m_stray = 1;
        if (idle) begin
            if (go && en) begin
                m_in_frame = 1;
                m_latched  = 0;
            end
        end else if (!m_latched) begin
            m_latched = 1; m_sent = 0; m_drain = 0; m_issue_cycles = 0;
            foreach (m_snap[i]) m_snap[i] = cam_in[i];
        end else if (m_sent < W) begin
            if (col_if.col_ready_in) begin
                m_sent++;
                if (m_sent == W) m_frame_done = 1;
            end
        end else if (done) begin
            m_in_frame = 0;
        end else begin
            m_drain++;
            if (m_drain == TO) begin
                m_in_frame = 0;
                m_tout     = 1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("valid", col_if.col_valid_out, exp_valid());
        check_eq("col", col_if.col_out, exp_col());
        check_eq("last", col_if.col_last_out, exp_valid() && (m_sent == W - 1));
        check_eq("busy", busy, m_in_frame);
        check_eq("skipped", skipped, m_skips);
        check_eq("timeout_err", tout, m_tout);
        check_eq("stray_err", stray, m_stray);
        foreach (cam_out[i]) check_eq($sformatf("snap%0d", i), cam_out[i], m_snap[i]);
        if (m_frame_done) begin
            int bad;
            bad = 0;
            m_frame_done = 0;
            m_frames++;
            foreach (seen[i]) begin
                if (seen[i] != 1) bad++;
                seen[i] = 0;
            end
            check_eq("col_once", bad, 0);
            $display("[TB] frame %0d: %0d columns once, %0d ISSUE cycles, cycle %0d",
                     m_frames, W - bad, m_issue_cycles, cyc);
        end
    endtask

    int cyc, dut_issue_cycles, gap_cycles;

    task automatic tick();
        if (col_if.col_valid_out === 1'b1 && col_if.col_ready_in === 1'b1 && col_if.col_out < W)
            seen[col_if.col_out]++;
        if (col_if.col_valid_out === 1'b1) dut_issue_cycles++;
        if (busy === 1'b1 && col_if.col_valid_out !== 1'b1) gap_cycles++;
        @(posedge clk);
        model_clock();
        #1;
        cyc++;
        compare_all();
    endtask

    int ready_mode, done_after, go_pct, done_pct, en_pct, rst_pct;
    bit cam_rand, done_on_last;

    task automatic set_inputs();
        case (ready_mode)
            0:       col_if.col_ready_in = 1'b1;
            1:       col_if.col_ready_in = (m_issue_cycles % 2) == 1;
            2:       col_if.col_ready_in = 1'($urandom_range(0, 1));
            3:       col_if.col_ready_in = 1'b0;
            default: col_if.col_ready_in = (m_sent < 100);
        endcase
        if (cam_rand) foreach (cam_in[i]) cam_in[i] = NW'($urandom);
        if (done_on_last)         done = exp_valid() && (m_sent == W - 1);
        else if (done_after >= 0) done = exp_drain() && (m_drain == done_after);
        else                      done = ($urandom_range(0, 99) < done_pct);
        if (go_pct > 0) begin
            go  = ($urandom_range(0, 99) < go_pct);
            en  = ($urandom_range(0, 99) < en_pct);
            rst = ($urandom_range(0, 999) < rst_pct);
        end
    endtask

    task automatic start_frame(input string tag);
        int n;
        dut_issue_cycles = 0;
        gap_cycles       = 0;
        set_inputs();
        go = 1'b1;
        en = 1'b1;
        tick();
        go = 1'b0;
        n  = 1;
        while (col_if.col_valid_out !== 1'b1 && n < 8) begin
            set_inputs();
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, n, 2);
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cycles) begin
            set_inputs();
            tick();
            n++;
        end
        check_eq({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        n_tests = 0; n_fail = 0; cyc = 0; m_frames = 0; m_frame_done = 0;
        dut_issue_cycles = 0; gap_cycles = 0;
        ready_mode = 0; done_after = 2; go_pct = 0; done_pct = 0; en_pct = 100; rst_pct = 0;
        cam_rand = 1; done_on_last = 0;
        rst = 1'b1; en = 1'b0; go = 1'b0; done = 1'b0; col_if.col_ready_in = 1'b0;
        foreach (cam_in[i]) cam_in[i] = NW'($urandom);
        tick();
        tick();
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_valid", col_if.col_valid_out, 1'b0);
        rst = 1'b0;

        // Full-rate frame with a fixed pos_x.
        cam_rand = 0;
        cam_in[CAM_POS_X] = 24'h012345;
        start_frame("a");
        check_eq("a_pos_x", col_if.pos_x_out, 24'h012345);
        run_until_idle("a", 2000);
        check_eq("a_issue_cycles", dut_issue_cycles, W);
        check_eq("a_gap_cycles", gap_cycles, 1 + 3);

        // Ready toggling, camera changing every cycle.
        cam_rand = 1; ready_mode = 1; done_after = 0;
        start_frame("b");
        run_until_idle("b", 2000);
        check_eq("b_issue_cycles", dut_issue_cycles, 2 * W);

        // Drain timeout, then a normal frame.
        ready_mode = 0; done_after = -1;
        start_frame("d");
        run_until_idle("d", 2000);
        check_eq("d_gap_cycles", gap_cycles, 1 + TO);
        check_eq("d_timeout", tout, 1'b1);
        done_after = 1;
        start_frame("d2");
        run_until_idle("d2", 2000);

        // render_done on the final transfer, then done+go together in DRAIN.
        done_on_last = 1;
        start_frame("e");
        n = 0;
        while (col_if.col_valid_out === 1'b1 && n < 2000) begin
            set_inputs();
            tick();
            n++;
        end
        check_eq("e_stray", stray, 1'b1);
        check_eq("e_busy", busy, 1'b1);
        done_on_last = 0; done_after = -1;
        set_inputs();
        tick();
        go = 1'b1; done = 1'b1;
        tick();
        go = 1'b0; done = 1'b0;
        check_eq("e_busy_after", busy, 1'b0);
        check_eq("e_skip", skipped, 1);
        tick();
        check_eq("e_no_latch", busy, 1'b0);

        // Skip counting and saturation while stalled in ISSUE.
        rst = 1'b1; tick(); rst = 1'b0;
        ready_mode = 3; done_after = 1;
        start_frame("c");
        for (int k = 0; k < 3; k++) begin
            go = 1'b1; tick(); go = 1'b0; tick(); tick();
        end
        check_eq("c_skip3", skipped, 3);
        go = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        go = 1'b0;
        check_eq("c_skip_sat", skipped, 255);
        ready_mode = 0;
        run_until_idle("c", 2000);

        // Reset while stalled at column 100, then a stray done in IDLE.
        rst = 1'b1; tick(); rst = 1'b0;
        ready_mode = 4;
        start_frame("f");
        n = 0;
        while (col_if.col_out != 100 && n < 500) begin
            set_inputs();
            tick();
            n++;
        end
        set_inputs(); tick();
        set_inputs(); tick();
        check_eq("f_col", col_if.col_out, 100);
        check_eq("f_valid", col_if.col_valid_out, 1'b1);
        rst = 1'b1; col_if.col_ready_in = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("f_rst_valid", col_if.col_valid_out, 1'b0);
        check_eq("f_rst_col", col_if.col_out, 0);
        check_eq("f_rst_busy", busy, 1'b0);
        check_eq("f_rst_pos_x", col_if.pos_x_out, 0);
        done = 1'b1; tick(); done = 1'b0;
        check_eq("f_stray", stray, 1'b1);
        check_eq("f_stray_busy", busy, 1'b0);

        // Randomized soak.
        ready_mode = 2; done_after = -1; done_pct = 3; go_pct = 4; en_pct = 70; rst_pct = 2;
        cam_rand = 1;
        for (int k = 0; k < 4000; k++) begin
            set_inputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
